// File: rtl/dmem_ctrl_pkg.sv
// Shared types and constants for the data-memory controller.
package dmem_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam int P_CPU      = 0;
    localparam int P_AUX      = 1;
    localparam int RD_LAT_DEF = 1;
    localparam int AW_DEF     = 32;
    localparam int DW_DEF     = 32;

endpackage

// File: rtl/dmem_ctrl_if.sv
// Request/ack port bundle for one memory master.
interface dmem_ctrl_if
    import dmem_ctrl_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) ();

    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          ack;

    modport master (output req, output we, output addr, output wdata, input ack);
    modport slave  (input req, input we, input addr, input wdata, output ack);

endinterface

// File: rtl/dmem_ctrl_rr_arb2.sv
// Two-way round-robin arbiter; pointer remembers the last granted port.
module rr_arb2
    import dmem_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] i_req,
    input  logic       i_advance,
    output logic [1:0] o_gnt,
    output logic       o_last
);

    logic r_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last <= 1'(P_AUX);
        end else if (i_advance) begin
            r_last <= o_gnt[1];
        end
    end

    // On contention, favour whichever port did not win last time.
    always_comb begin
        o_gnt = i_req;
        if (&i_req) begin
            o_gnt = r_last ? 2'b01 : 2'b10;
        end
    end

    assign o_last = r_last;

endmodule

// File: rtl/dmem_ctrl.sv
// Two-port arbiter/sequencer for a single-port BRAM on a shared tri-state dbus.
module dmem_ctrl
    import dmem_ctrl_pkg::*;
#(
    parameter int DW     = DW_DEF,
    parameter int AW     = AW_DEF,
    parameter int RD_LAT = RD_LAT_DEF
) (
    input  logic          clk,
    input  logic          rst,
    dmem_ctrl_if.slave    p0,
    dmem_ctrl_if.slave    p1,
    output logic [DW-1:0] rdata,
    output logic          busy,
    output logic [AW-1:0] mem_addr,
    output logic          mem_en,
    output logic          mem_we,
    inout  wire  [DW-1:0] dbus
);

    localparam logic [1:0] CNT_LAST = 2'(RD_LAT);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [1:0]    r_cnt;
    logic [1:0]    w_cnt_nxt;
    logic          w_capture;
    logic          r_we;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;
    logic [DW-1:0] r_rdata;
    logic [1:0]    w_req;
    logic [1:0]    w_gnt;
    logic          w_advance;
    logic          w_last;
    logic          w_dbus_oe;

    assign w_req     = {p1.req, p0.req};
    assign w_advance = (r_state == ST_IDLE) && (|w_req);

    rr_arb2 u_arb (
        .clk       (clk),
        .rst       (rst),
        .i_req     (w_req),
        .i_advance (w_advance),
        .o_gnt     (w_gnt),
        .o_last    (w_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_capture   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (|w_req) begin
                    w_state_nxt = ST_ACCESS;
                    w_cnt_nxt   = 2'd0;
                end
            end
            ST_ACCESS: begin
                if (r_we) begin
                    w_state_nxt = ST_DONE;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = ST_DONE;
                    w_capture   = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 2'd1;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            if (w_advance) begin
                r_we    <= w_gnt[1] ? p1.we    : p0.we;
                r_addr  <= w_gnt[1] ? p1.addr  : p0.addr;
                r_wdata <= w_gnt[1] ? p1.wdata : p0.wdata;
            end
            if (w_capture) begin
                r_rdata <= dbus;
            end
        end
    end

    // Arbiter pointer is loaded with the winner on the grant edge, so it names the owner in DONE.
    assign mem_en    = (r_state == ST_ACCESS);
    assign mem_we    = mem_en & r_we;
    assign mem_addr  = mem_en ? r_addr : '0;
    assign w_dbus_oe = mem_en & mem_we;
    assign dbus      = w_dbus_oe ? r_wdata : {DW{1'bz}};

    assign p0.ack = (r_state == ST_DONE) & ~w_last;
    assign p1.ack = (r_state == ST_DONE) &  w_last;
    assign busy   = (r_state != ST_IDLE);
    assign rdata  = r_rdata;

endmodule
